// File: rtl/mem_arbiter_ctrl.sv
// Shares one byte-wide RAM port between instruction fetch and the MEM stage, splitting 1/2/4-byte
// accesses into little-endian byte cycles. Define MEM_ARBITER_RR_EN for round-robin arbitration.
module mem_arbiter_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_done_o,
   output logic [DATA_W-1:0] if_data_o,
   input  logic              mem_req_i,
   input  logic              mem_wr_i,
   input  logic [1:0]        mem_size_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] mem_wdata_i,
   output logic              mem_done_o,
   output logic [DATA_W-1:0] mem_rdata_o,
   input  logic [7:0]        ram_din_i,
   output logic [7:0]        ram_dout_o,
   output logic [ADDR_W-1:0] ram_a_o,
   output logic              ram_wr_o,
   output logic              busy_o
);
   typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, DONE = 2'd3} state_t;
   localparam logic OWNER_IF  = 1'b0;
   localparam logic OWNER_MEM = 1'b1;

   function automatic logic [2:0] size_to_n(input logic [1:0] size);
      case (size)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic [7:0] byte_of(input logic [DATA_W-1:0] d, input logic [1:0] idx);
      return d[{idx, 3'b000} +: 8];
   endfunction

   function automatic logic [ADDR_W-1:0] addr_off(input logic [ADDR_W-1:0] a, input logic [2:0] off);
      return a + {{(ADDR_W-3){1'b0}}, off};
   endfunction

   state_t              state_q, state_d;
   logic [2:0]          cnt_q, cnt_d, n_q, n_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d, buf_q, buf_d;
   logic                owner_q, owner_d;
   logic [DATA_W-1:0]   if_data_q, if_data_d, mem_rdata_q, mem_rdata_d;
   logic                if_done_q, if_done_d, mem_done_q, mem_done_d;
   logic [ADDR_W-1:0]   ram_a_q, ram_a_d;
   logic [7:0]          ram_dout_q, ram_dout_d;
   logic                ram_wr_q, ram_wr_d, busy_q, busy_d;

   logic                any_req_s, grant_mem_s, sel_wr_s;
   logic [ADDR_W-1:0]   sel_addr_s;
   logic [DATA_W-1:0]   sel_wdata_s;
   logic [2:0]          sel_n_s;
   logic [1:0]          rd_idx_s;

   assign any_req_s = if_req_i | mem_req_i;
   // Byte arriving now belongs to the address issued one cycle earlier.
   assign rd_idx_s  = cnt_q[1:0] - 2'd1;

`ifdef MEM_ARBITER_RR_EN
   logic last_grant_q, last_grant_d;

   // Contested grant goes to whoever was not granted last; every grant is remembered.
   always_comb begin
      grant_mem_s = mem_req_i & (~if_req_i | (last_grant_q == OWNER_IF));
      if ((state_q == IDLE) && any_req_s) begin
         last_grant_d = grant_mem_s;
      end else begin
         last_grant_d = last_grant_q;
      end
   end

   // Last-grant register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         last_grant_q <= OWNER_IF;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end
`else
   // Fixed priority: MEM always beats IF.
   always_comb begin
      grant_mem_s = mem_req_i;
   end
`endif

   // Pick the winning requester's transaction fields.
   always_comb begin
      if (grant_mem_s) begin
         sel_addr_s  = mem_addr_i;
         sel_wdata_s = mem_wdata_i;
         sel_n_s     = size_to_n(mem_size_i);
         sel_wr_s    = mem_wr_i;
      end else begin
         sel_addr_s  = if_addr_i;
         sel_wdata_s = '0;
         sel_n_s     = 3'd4;
         sel_wr_s    = 1'b0;
      end
   end

   // Next state; RAM outputs are computed one cycle ahead so they leave straight from flops.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      n_d         = n_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      owner_d     = owner_q;
      buf_d       = buf_q;
      if_data_d   = if_data_q;
      mem_rdata_d = mem_rdata_q;
      if_done_d   = 1'b0;
      mem_done_d  = 1'b0;
      ram_a_d     = '0;
      ram_dout_d  = 8'h00;
      ram_wr_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (any_req_s) begin
               owner_d = grant_mem_s;
               addr_d  = sel_addr_s;
               wdata_d = sel_wdata_s;
               n_d     = sel_n_s;
               cnt_d   = 3'd0;
               buf_d   = '0;
               ram_a_d = sel_addr_s;
               if (sel_wr_s) begin
                  state_d    = WR;
                  ram_dout_d = byte_of(sel_wdata_s, 2'd0);
                  ram_wr_d   = 1'b1;
               end else begin
                  state_d = RD;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RD: begin
            if (cnt_q != 3'd0) begin
               buf_d[{rd_idx_s, 3'b000} +: 8] = ram_din_i;
            end else begin
               buf_d = buf_q;
            end
            if (cnt_q == n_q) begin
               state_d = DONE;
               cnt_d   = 3'd0;
               if (owner_q == OWNER_MEM) begin
                  mem_done_d  = 1'b1;
                  mem_rdata_d = buf_d;
               end else begin
                  if_done_d = 1'b1;
                  if_data_d = buf_d;
               end
            end else begin
               cnt_d = cnt_q + 3'd1;
               if (cnt_d < n_q) begin
                  ram_a_d = addr_off(addr_q, cnt_d);
               end else begin
                  ram_a_d = '0;
               end
            end
         end
         WR: begin
            if (cnt_q == (n_q - 3'd1)) begin
               state_d = DONE;
               cnt_d   = 3'd0;
               if (owner_q == OWNER_MEM) begin
                  mem_done_d = 1'b1;
               end else begin
                  if_done_d = 1'b1;
               end
            end else begin
               cnt_d      = cnt_q + 3'd1;
               ram_a_d    = addr_off(addr_q, cnt_d);
               ram_dout_d = byte_of(wdata_q, cnt_d[1:0]);
               ram_wr_d   = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= 3'd0;
         n_q         <= 3'd0;
         addr_q      <= '0;
         wdata_q     <= '0;
         owner_q     <= OWNER_IF;
         buf_q       <= '0;
         if_data_q   <= '0;
         mem_rdata_q <= '0;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
         ram_a_q     <= '0;
         ram_dout_q  <= 8'h00;
         ram_wr_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         n_q         <= n_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         owner_q     <= owner_d;
         buf_q       <= buf_d;
         if_data_q   <= if_data_d;
         mem_rdata_q <= mem_rdata_d;
         if_done_q   <= if_done_d;
         mem_done_q  <= mem_done_d;
         ram_a_q     <= ram_a_d;
         ram_dout_q  <= ram_dout_d;
         ram_wr_q    <= ram_wr_d;
         busy_q      <= busy_d;
      end
   end

   assign if_done_o   = if_done_q;
   assign if_data_o   = if_data_q;
   assign mem_done_o  = mem_done_q;
   assign mem_rdata_o = mem_rdata_q;
   assign ram_a_o     = ram_a_q;
   assign ram_dout_o  = ram_dout_q;
   assign ram_wr_o    = ram_wr_q;
   assign busy_o      = busy_q;
endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Scoreboard bench for mem_arbiter_ctrl: a byte-array reference memory predicts each completion
// (port, cycle, both data outputs); a monitor checks every done pulse against the queue.
module tb_mem_arbiter_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req_i = 1'b0;
   logic [31:0] if_addr_i = 32'h0;
   logic        if_done_o;
   logic [31:0] if_data_o;
   logic        mem_req_i = 1'b0;
   logic        mem_wr_i = 1'b0;
   logic [1:0]  mem_size_i = 2'b00;
   logic [31:0] mem_addr_i = 32'h0;
   logic [31:0] mem_wdata_i = 32'h0;
   logic        mem_done_o;
   logic [31:0] mem_rdata_o;
   logic [7:0]  ram_din_i = 8'h00;
   logic [7:0]  ram_dout_o;
   logic [31:0] ram_a_o;
   logic        ram_wr_o;
   logic        busy_o;

   logic [7:0]  ram     [0:1023] = '{default: 8'h00};
   logic [7:0]  ref_mem [0:1023] = '{default: 8'h00};
   logic        poke_en = 1'b0;
   logic [31:0] poke_a = 32'h0;
   logic [7:0]  poke_d = 8'h00;

   int cyc = 0;
   int total = 0;
   int bad = 0;

   typedef struct {
      bit          port;     // 1 = MEM, 0 = IF
      int          cyc;
      logic [31:0] exp_if;
      logic [31:0] exp_mem;
   } exp_t;
   exp_t sb[$];

   logic [31:0] m_if = 32'h0;
   logic [31:0] m_mem = 32'h0;
   bit          m_last_mem = 1'b0;

   mem_arbiter_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_done_o(if_done_o), .if_data_o(if_data_o),
      .mem_req_i(mem_req_i), .mem_wr_i(mem_wr_i), .mem_size_i(mem_size_i), .mem_addr_i(mem_addr_i),
      .mem_wdata_i(mem_wdata_i), .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o),
      .ram_din_i(ram_din_i), .ram_dout_o(ram_dout_o), .ram_a_o(ram_a_o), .ram_wr_o(ram_wr_o),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Byte RAM: synchronous write, read data valid the cycle after the address.
   always @(posedge clk) begin
      if (poke_en) ram[poke_a[9:0]] <= poke_d;
      else if (ram_wr_o) ram[ram_a_o[9:0]] <= ram_dout_o;
      ram_din_i <= ram[ram_a_o[9:0]];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int n_of(input logic [1:0] size);
      return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
   endfunction

   function automatic int lat(input bit wr, input int n);
      return wr ? n + 1 : n + 2;
   endfunction

   task automatic poke(input logic [31:0] a, input logic [7:0] d);
      poke_a = a; poke_d = d; poke_en = 1'b1;
      @(posedge clk); #1;
      poke_en = 1'b0;
      ref_mem[a[9:0]] = d;
   endtask

   // Apply one access to the reference memory and queue the completion it must produce.
   task automatic model_op(input bit port, input bit wr, input int n, input logic [31:0] a,
                           input logic [31:0] wd, input int done_cyc);
      logic [31:0] r;
      logic [31:0] ai;
      exp_t e;
      r = 32'h0;
      for (int i = 0; i < n; i++) begin
         ai = a + i;
         if (wr) ref_mem[ai[9:0]] = wd[8*i +: 8];
         else r[8*i +: 8] = ref_mem[ai[9:0]];
      end
      if (!wr) begin
         if (port) m_mem = r;
         else m_if = r;
      end
      e.port = port; e.cyc = done_cyc; e.exp_if = m_if; e.exp_mem = m_mem;
      sb.push_back(e);
   endtask

   task automatic do_single(input bit port, input bit wr, input logic [1:0] size,
                            input logic [31:0] a, input logic [31:0] wd);
      int n;
      bit w;
      bit got;
      n = port ? n_of(size) : 4;
      w = port & wr;
      model_op(port, w, n, a, wd, cyc + lat(w, n));
      m_last_mem = port;
      if (port) begin
         mem_req_i = 1'b1; mem_wr_i = wr; mem_size_i = size; mem_addr_i = a; mem_wdata_i = wd;
      end else begin
         if_req_i = 1'b1; if_addr_i = a;
      end
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (port ? mem_done_o : if_done_o) got = 1'b1;
      end
      chk("done_seen", {31'h0, got}, 32'h1);
      if_req_i = 1'b0;
      mem_req_i = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic do_contest(input bit mwr, input logic [1:0] size, input logic [31:0] ma,
                             input logic [31:0] wd, input logic [31:0] ia);
      int t;
      int mn;
      int d1;
      bit mem_first;
      t = cyc;
      mn = n_of(size);
      mem_first = 1'b1;
`ifdef MEM_ARBITER_RR_EN
      mem_first = ~m_last_mem;
`endif
      if (mem_first) begin
         d1 = t + lat(mwr, mn);
         model_op(1'b1, mwr, mn, ma, wd, d1);
         model_op(1'b0, 1'b0, 4, ia, 32'h0, d1 + 1 + lat(1'b0, 4));
         m_last_mem = 1'b0;
      end else begin
         d1 = t + lat(1'b0, 4);
         model_op(1'b0, 1'b0, 4, ia, 32'h0, d1);
         model_op(1'b1, mwr, mn, ma, wd, d1 + 1 + lat(mwr, mn));
         m_last_mem = 1'b1;
      end
      mem_req_i = 1'b1; mem_wr_i = mwr; mem_size_i = size; mem_addr_i = ma; mem_wdata_i = wd;
      if_req_i = 1'b1; if_addr_i = ia;
      for (int k = 0; k < 40 && (if_req_i || mem_req_i); k++) begin
         @(negedge clk);
         if (mem_done_o) mem_req_i = 1'b0;
         if (if_done_o) if_req_i = 1'b0;
      end
      chk("contest_both_done", {30'h0, if_req_i, mem_req_i}, 32'h0);
      if_req_i = 1'b0;
      mem_req_i = 1'b0;
      @(posedge clk); #1;
   endtask

   // Monitor: every done pulse must match the head of the scoreboard.
   exp_t me;
   always @(negedge clk) begin
      if (rst) begin
         if (if_done_o || mem_done_o) begin
            chk("single_done", {31'h0, if_done_o & mem_done_o}, 32'h0);
            if (sb.size() == 0) begin
               chk("unexpected_done", {31'h0, mem_done_o}, {31'h0, ~mem_done_o});
            end else begin
               me = sb.pop_front();
               chk("done_port", {31'h0, mem_done_o}, {31'h0, me.port});
               chk("done_cycle", cyc, me.cyc);
               chk("if_data", if_data_o, me.exp_if);
               chk("mem_rdata", mem_rdata_o, me.exp_mem);
            end
         end
         if (!busy_o) chk("idle_ram_wr", {31'h0, ram_wr_o}, 32'h0);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int mism;
      int kind;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'h0, busy_o}, 32'h0);
      chk("rst_if_data", if_data_o, 32'h0);
      chk("rst_mem_rdata", mem_rdata_o, 32'h0);
      chk("rst_ram_a", ram_a_o, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;

      poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
      do_single(1'b0, 1'b0, 2'b10, 32'h100, 32'h0);
      do_single(1'b1, 1'b1, 2'b10, 32'h200, 32'hDEADBEEF);
      poke(32'h201, 8'hAD);
      do_single(1'b1, 1'b0, 2'b00, 32'h201, 32'h0);
      do_single(1'b1, 1'b0, 2'b01, 32'h202, 32'h0);
      do_single(1'b1, 1'b1, 2'b00, 32'h204, 32'h12345678);
      do_single(1'b1, 1'b0, 2'b10, 32'h200, 32'h0);
      do_contest(1'b0, 2'b10, 32'h200, 32'h0, 32'h100);
      do_single(1'b1, 1'b1, 2'b01, 32'h206, 32'h0000CAFE);
      do_contest(1'b0, 2'b00, 32'h203, 32'h0, 32'h104);
      do_single(1'b1, 1'b1, 2'b10, 32'hFFFFFFFE, 32'hA1B2C3D4);
      do_single(1'b0, 1'b0, 2'b10, 32'hFFFFFFFE, 32'h0);

      // Reset during RD with cnt = 2: no done, all outputs cleared.
      if_req_i = 1'b1; if_addr_i = 32'h100;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      if_req_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      m_if = 32'h0; m_mem = 32'h0; m_last_mem = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy", {31'h0, busy_o}, 32'h0);
      chk("mid_rst_if_data", if_data_o, 32'h0);
      chk("mid_rst_mem_rdata", mem_rdata_o, 32'h0);
      chk("mid_rst_ram_a", ram_a_o, 32'h0);
      chk("mid_rst_done", {30'h0, if_done_o, mem_done_o}, 32'h0);
      @(posedge clk); #1;
      do_single(1'b0, 1'b0, 2'b10, 32'h100, 32'h0);

      for (int it = 0; it < 40; it++) begin
         kind = $urandom_range(0, 3);
         case (kind)
            0: do_single(1'b0, 1'b0, 2'b10, 32'h300 + $urandom_range(0, 15), 32'h0);
            2: do_contest(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          32'h300 + $urandom_range(0, 15), $urandom, 32'h300 + $urandom_range(0, 15));
            default: do_single(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                               32'h300 + $urandom_range(0, 15), $urandom);
         endcase
      end

      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard_empty", sb.size(), 32'h0);
      mism = 0;
      for (int i = 0; i < 1024; i++) begin
         if (ram[i] !== ref_mem[i]) mism++;
      end
      chk("ram_image", mism, 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
